matrix_value_locator: RTL and testbench
=======================================

# matrix_value_locator

Read-side companion to the search-and-assign writer in the Lab 4 datapath. Given a 6-bit key, the block scans the 8x8 result matrix of 10-bit entries through a synchronous single-port read interface, one cell per cycle in row-major order. It returns the coordinates and full stored word of the first entry whose value field equals the key, or a not-found response. Requests and responses use valid/ready handshakes, so the display and game-control logic can query the matrix without touching the writer.

## Interface
- ROWS, 8, matrix rows; address row field is log2(ROWS)=3 bits
- COLS, 8, matrix columns; address column field is log2(COLS)=3 bits
- DATA_W, 10, stored entry width
- KEY_W, 6, key width; compared against entry[KEY_W-1:0]
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_key  in  KEY_W  value to locate
- mem_en  out  1  read enable to matrix storage
- mem_addr  out  6  cell index = {row, col}, row-major
- mem_rdata  in  DATA_W  entry for the address presented on the previous cycle (1-cycle read latency)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_found  out  1  1 = match, 0 = key absent
- rsp_row  out  3  row of match (0 if not found)
- rsp_col  out  3  column of match (0 if not found)
- rsp_entry  out  DATA_W  full matching entry (0 if not found)

## Operation
- All outputs registered. Reset values (while rst=0): req_ready=0, rsp_valid=0, rsp_found=0, rsp_row=0, rsp_col=0, rsp_entry=0, mem_en=0, mem_addr=0; FSM in IDLE.
- The FSM has three states: IDLE, SCAN, RESP.
- IDLE: req_ready=1. Acceptance occurs when req_valid and req_ready are both 1 at a rising edge. On acceptance, capture req_key, drop req_ready, and go to SCAN.
- SCAN: issue addresses 0..63 on consecutive cycles with mem_en=1. Each cycle, compare mem_rdata[5:0] against the captured key for the address issued on the previous cycle.
  - First match at index n: register found=1, row=n[5:3], col=n[2:0], entry=mem_rdata, then go to RESP.
  - Scanning stops at the first match. Lower indices always take priority over duplicates at higher indices.
  - One speculative read past the match index is allowed. mem_en drops to 0 on the first cycle of RESP.
  - After address 63, mem_en=0. If the compare for index 63 misses, register found=0, row=col=entry=0, and go to RESP.
- RESP: rsp_valid=1. All rsp_* outputs are held stable until rsp_ready=1 at a rising edge. On that edge, rsp_valid is cleared, the FSM returns to IDLE, and req_ready=1 on the next cycle.
- Key upper entry bits (entry[9:6]) are ignored for matching but are returned in rsp_entry.
- No request is accepted outside IDLE. req_key changes outside IDLE are ignored.
- mem_addr holds its last value when mem_en=0.
- rst=0 at any time, including mid-scan or mid-response, aborts immediately. All outputs take reset values on the next edge, with no partial response.

## Timing
- Cycle 0 = the cycle in which the request is accepted.
- mem_addr=k with mem_en=1 in cycle k+1. mem_rdata for k is valid in cycle k+2.
- Match at index n: rsp_valid first high in cycle n+3. Best case (n=0) is 3 cycles; worst case found (n=63) is 66 cycles.
- Not found: rsp_valid first high in cycle 66.
- If rsp_ready is already 1 when rsp_valid rises, the response completes in 1 cycle. req_ready is then high 1 cycle later.
- Back-to-back throughput: one request per (latency + 2) cycles minimum.
- First cycle after rst rises: req_ready=1.

## Test plan
- Reset check: hold rst=0 for 3 cycles with req_valid=1 -> all outputs at reset values, no acceptance. Release rst -> req_ready=1 next cycle.
- Single hit at [0][0]: matrix[0][0]=10'b1010_000101, key=5 -> rsp_valid in cycle 3, found=1, row=0, col=0, entry=10'b1010000101.
- Last-cell hit and miss: key 42 only at [7][7] -> rsp_valid cycle 66, row=7, col=7. Key 63 absent -> rsp_valid cycle 66, found=0, row=col=entry=0.
- Duplicates: key 17 at [2][3] and [5][1] -> row=2, col=3, latency 22 (n=19). Entries with equal low bits but different upper bits still match.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_* stable and req_ready=0 throughout. rsp_ready pulse -> rsp_valid=0 next cycle and req_ready=1 one cycle after acceptance.
- Mid-scan reset: rst=0 at cycle 20 of a scan -> reset values on the next edge, no rsp_valid. A new request after release completes with correct result.

Source files
------------

// File: rtl/matrix_value_locator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : matrix_value_locator
// Purpose  : Scans a ROWS x COLS matrix held in a synchronous single-port
//            storage (1-cycle read latency), one cell per cycle in row-major
//            order. Returns the first cell whose low KEY_W bits equal the
//            requested key, or a not-found response.
// Ports    : clk, rst (sync, active-low)
//            req_valid_i / req_ready_o / req_key_i         : request handshake
//            mem_en_o / mem_addr_o / mem_rdata_i           : storage read port
//            rsp_valid_o / rsp_ready_i                     : response handshake
//            rsp_found_o / rsp_row_o / rsp_col_o / rsp_entry_o : result
// Revision : 1.0 - initial release
// ============================================================================
module matrix_value_locator #(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int DATA_W = 10,
  parameter int KEY_W  = 6
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  req_valid_i,
  output logic                                  req_ready_o,
  input  logic [KEY_W-1:0]                      req_key_i,
  output logic                                  mem_en_o,
  output logic [$clog2(ROWS)+$clog2(COLS)-1:0]  mem_addr_o,
  input  logic [DATA_W-1:0]                     mem_rdata_i,
  output logic                                  rsp_valid_o,
  input  logic                                  rsp_ready_i,
  output logic                                  rsp_found_o,
  output logic [$clog2(ROWS)-1:0]               rsp_row_o,
  output logic [$clog2(COLS)-1:0]               rsp_col_o,
  output logic [DATA_W-1:0]                     rsp_entry_o
);

  localparam int ROW_W  = $clog2(ROWS);
  localparam int COL_W  = $clog2(COLS);
  localparam int ADDR_W = ROW_W + COL_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ROWS * COLS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic                req_ready_q, req_ready_d;
  logic                mem_en_q, mem_en_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                found_q, found_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [DATA_W-1:0]   entry_q, entry_d;

  // Read pipeline tracker: which address the current mem_rdata_i belongs to.
  logic                cmp_valid_q;
  logic [ADDR_W-1:0]   cmp_idx_q;

  logic                hit;
  assign hit = cmp_valid_q && (mem_rdata_i[KEY_W-1:0] == key_q);

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    req_ready_d = 1'b0;
    mem_en_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    rsp_valid_d = rsp_valid_q;
    found_d     = found_q;
    row_d       = row_q;
    col_d       = col_q;
    entry_d     = entry_q;

    case (state_q)
      IDLE: begin
        // req_ready rises one cycle after entering IDLE (after reset or a
        // completed response), since it is registered from the state.
        req_ready_d = 1'b1;
        if (req_valid_i && req_ready_q) begin
          key_d       = req_key_i;
          req_ready_d = 1'b0;
          mem_en_d    = 1'b1;
          mem_addr_d  = '0;
          state_d     = SCAN;
        end
      end

      SCAN: begin
        // Keep issuing reads until the last cell has been addressed.
        if (mem_en_q && (mem_addr_q != LAST_IDX)) begin
          mem_en_d   = 1'b1;
          mem_addr_d = mem_addr_q + ADDR_W'(1);
        end
        if (hit) begin
          // The read issued this cycle was speculative; stop and hold addr.
          mem_en_d    = 1'b0;
          mem_addr_d  = mem_addr_q;
          found_d     = 1'b1;
          row_d       = cmp_idx_q[ADDR_W-1:COL_W];
          col_d       = cmp_idx_q[COL_W-1:0];
          entry_d     = mem_rdata_i;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (cmp_valid_q && (cmp_idx_q == LAST_IDX)) begin
          found_d     = 1'b0;
          row_d       = '0;
          col_d       = '0;
          entry_d     = '0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end

      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      key_q       <= '0;
      req_ready_q <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      found_q     <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      entry_q     <= '0;
      cmp_valid_q <= 1'b0;
      cmp_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      req_ready_q <= req_ready_d;
      mem_en_q    <= mem_en_d;
      mem_addr_q  <= mem_addr_d;
      rsp_valid_q <= rsp_valid_d;
      found_q     <= found_d;
      row_q       <= row_d;
      col_q       <= col_d;
      entry_q     <= entry_d;
      cmp_valid_q <= mem_en_q;
      cmp_idx_q   <= mem_addr_q;
    end
  end

  assign req_ready_o = req_ready_q;
  assign mem_en_o    = mem_en_q;
  assign mem_addr_o  = mem_addr_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_found_o = found_q;
  assign rsp_row_o   = row_q;
  assign rsp_col_o   = col_q;
  assign rsp_entry_o = entry_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_value_locator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_matrix_value_locator
// Purpose  : Directed self-checking bench for matrix_value_locator with a
//            behavioural 64-entry synchronous matrix store.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_value_locator;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid_i = 1'b0;
  logic       req_ready_o;
  logic [5:0] req_key_i = '0;
  logic       mem_en_o;
  logic [5:0] mem_addr_o;
  logic [9:0] mem_rdata_i = '0;
  logic       rsp_valid_o;
  logic       rsp_ready_i = 1'b0;
  logic       rsp_found_o;
  logic [2:0] rsp_row_o;
  logic [2:0] rsp_col_o;
  logic [9:0] rsp_entry_o;

  int checks = 0;
  int errors = 0;

  logic [9:0] mem [64];

  always #5 clk = ~clk;

  // Synchronous storage, 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_en_o) mem_rdata_i <= mem[mem_addr_o];
  end

  matrix_value_locator dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_key_i   (req_key_i),
    .mem_en_o    (mem_en_o),
    .mem_addr_o  (mem_addr_o),
    .mem_rdata_i (mem_rdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_found_o (rsp_found_o),
    .rsp_row_o   (rsp_row_o),
    .rsp_col_o   (rsp_col_o),
    .rsp_entry_o (rsp_entry_o)
  );

  // Background fill: low bits 0 never equal any key used below.
  task automatic fill_default();
    for (int i = 0; i < 64; i++) mem[i] = {i[3:0], 6'd0};
  endtask

  // Issue a request; return the cycle (relative to acceptance) in which
  // rsp_valid is first seen high, or -1 on timeout. Returns at the negedge
  // of that cycle.
  task automatic send(input logic [5:0] key, output int lat);
    int c;
    lat = -1;
    @(negedge clk);
    req_valid_i = 1'b1;
    req_key_i   = key;
    c = 0;
    while (!req_ready_o && c < 10) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    req_valid_i = 1'b0;
    req_key_i   = ~key;
    c = 1;
    while (!rsp_valid_o && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (rsp_valid_o) lat = c;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid_i = 1'b1;
    req_key_i = 6'd5;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready_o !== 1'b0 || rsp_valid_o !== 1'b0 || mem_en_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got rdy=%b vld=%b en=%b want 0 0 0", req_ready_o, rsp_valid_o, mem_en_o);
    end
    checks++;
    if (rsp_found_o !== 1'b0 || rsp_row_o !== 3'd0 || rsp_col_o !== 3'd0 ||
        rsp_entry_o !== 10'd0 || mem_addr_o !== 6'd0) begin
      errors++;
      $display("FAIL reset_data got f=%b r=%0d c=%0d e=%0h a=%0d want all 0",
               rsp_found_o, rsp_row_o, rsp_col_o, rsp_entry_o, mem_addr_o);
    end
    req_valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b want 1", req_ready_o);
    end
  endtask

  task automatic test_hit_first();
    int lat;
    fill_default();
    mem[0] = 10'b1010_000101;
    rsp_ready_i = 1'b1;
    send(6'd5, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL hit00_latency got %0d want 3", lat); end
    checks++;
    if (rsp_found_o !== 1'b1 || rsp_row_o !== 3'd0 || rsp_col_o !== 3'd0 || rsp_entry_o !== 10'b1010000101) begin
      errors++;
      $display("FAIL hit00_result got f=%b r=%0d c=%0d e=%0h want 1 0 0 285", rsp_found_o, rsp_row_o, rsp_col_o, rsp_entry_o);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b0 || mem_en_o !== 1'b0) begin
      errors++;
      $display("FAIL hit00_after got vld=%b rdy=%b en=%b want 0 0 0", rsp_valid_o, req_ready_o, mem_en_o);
    end
    @(negedge clk);
    checks++;
    if (req_ready_o !== 1'b1) begin errors++; $display("FAIL hit00_rearm got %b want 1", req_ready_o); end
  endtask

  task automatic test_last_and_miss();
    int lat;
    fill_default();
    mem[63] = {4'h3, 6'd42};
    rsp_ready_i = 1'b1;
    send(6'd42, lat);
    checks++;
    if (lat !== 66) begin errors++; $display("FAIL last_latency got %0d want 66", lat); end
    checks++;
    if (rsp_found_o !== 1'b1 || rsp_row_o !== 3'd7 || rsp_col_o !== 3'd7 || rsp_entry_o !== 10'h0EA) begin
      errors++;
      $display("FAIL last_result got f=%b r=%0d c=%0d e=%0h want 1 7 7 0ea", rsp_found_o, rsp_row_o, rsp_col_o, rsp_entry_o);
    end
    checks++;
    if (mem_en_o !== 1'b0 || mem_addr_o !== 6'd63) begin
      errors++;
      $display("FAIL last_mem got en=%b a=%0d want 0 63", mem_en_o, mem_addr_o);
    end
    repeat (2) @(negedge clk);
    send(6'd63, lat);
    checks++;
    if (lat !== 66) begin errors++; $display("FAIL miss_latency got %0d want 66", lat); end
    checks++;
    if (rsp_found_o !== 1'b0 || rsp_row_o !== 3'd0 || rsp_col_o !== 3'd0 || rsp_entry_o !== 10'd0) begin
      errors++;
      $display("FAIL miss_result got f=%b r=%0d c=%0d e=%0h want 0 0 0 0", rsp_found_o, rsp_row_o, rsp_col_o, rsp_entry_o);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_duplicates();
    int lat;
    fill_default();
    mem[19] = {4'h2, 6'd17};
    mem[41] = {4'h9, 6'd17};
    rsp_ready_i = 1'b1;
    send(6'd17, lat);
    checks++;
    if (lat !== 22) begin errors++; $display("FAIL dup_latency got %0d want 22", lat); end
    checks++;
    if (rsp_found_o !== 1'b1 || rsp_row_o !== 3'd2 || rsp_col_o !== 3'd3 || rsp_entry_o !== 10'h091) begin
      errors++;
      $display("FAIL dup_result got f=%b r=%0d c=%0d e=%0h want 1 2 3 091", rsp_found_o, rsp_row_o, rsp_col_o, rsp_entry_o);
    end
    repeat (2) @(negedge clk);
    // Upper bits differ from the key's implied zero upper bits; still a match.
    mem[19] = {4'h2, 6'd0};
    send(6'd17, lat);
    checks++;
    if (lat !== 44) begin errors++; $display("FAIL upper_latency got %0d want 44", lat); end
    checks++;
    if (rsp_found_o !== 1'b1 || rsp_row_o !== 3'd5 || rsp_col_o !== 3'd1 || rsp_entry_o !== 10'h251) begin
      errors++;
      $display("FAIL upper_result got f=%b r=%0d c=%0d e=%0h want 1 5 1 251", rsp_found_o, rsp_row_o, rsp_col_o, rsp_entry_o);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat;
    fill_default();
    mem[10] = {4'hC, 6'd33};
    rsp_ready_i = 1'b0;
    send(6'd33, lat);
    checks++;
    if (lat !== 13) begin errors++; $display("FAIL bp_latency got %0d want 13", lat); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid_o !== 1'b1 || req_ready_o !== 1'b0 || rsp_found_o !== 1'b1 ||
          rsp_row_o !== 3'd1 || rsp_col_o !== 3'd2 || rsp_entry_o !== 10'h321) begin
        errors++;
        $display("FAIL bp_hold[%0d] got v=%b rdy=%b f=%b r=%0d c=%0d e=%0h want 1 0 1 1 2 321",
                 i, rsp_valid_o, req_ready_o, rsp_found_o, rsp_row_o, rsp_col_o, rsp_entry_o);
      end
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    checks++;
    if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got vld=%b rdy=%b want 0 0", rsp_valid_o, req_ready_o);
    end
    @(negedge clk);
    checks++;
    if (req_ready_o !== 1'b1) begin errors++; $display("FAIL bp_rearm got %b want 1", req_ready_o); end
  endtask

  task automatic test_midscan_reset();
    int lat;
    int c;
    fill_default();
    mem[19] = {4'h2, 6'd17};
    mem[63] = {4'h3, 6'd42};
    rsp_ready_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b1;
    req_key_i = 6'd42;
    c = 0;
    while (!req_ready_o && c < 10) begin @(negedge clk); c++; end
    @(negedge clk);               // cycle 1
    req_valid_i = 1'b0;
    repeat (19) @(negedge clk);   // cycle 20
    checks++;
    if (mem_en_o !== 1'b1 || mem_addr_o !== 6'd19) begin
      errors++;
      $display("FAIL mid_scanning got en=%b a=%0d want 1 19", mem_en_o, mem_addr_o);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_en_o !== 1'b0 || mem_addr_o !== 6'd0 || rsp_valid_o !== 1'b0 || req_ready_o !== 1'b0 || rsp_found_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got en=%b a=%0d vld=%b rdy=%b f=%b want 0 0 0 0 0",
               mem_en_o, mem_addr_o, rsp_valid_o, req_ready_o, rsp_found_o);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (rsp_valid_o !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL mid_no_rsp got vld=1 at %0d want 0", i);
        break;
      end
    end
    send(6'd17, lat);
    checks++;
    if (lat !== 22 || rsp_found_o !== 1'b1 || rsp_row_o !== 3'd2 || rsp_col_o !== 3'd3 || rsp_entry_o !== 10'h091) begin
      errors++;
      $display("FAIL mid_after got lat=%0d f=%b r=%0d c=%0d e=%0h want 22 1 2 3 091",
               lat, rsp_found_o, rsp_row_o, rsp_col_o, rsp_entry_o);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    fill_default();
    test_reset();
    test_hit_first();
    test_last_and_miss();
    test_duplicates();
    test_backpressure();
    test_midscan_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
